// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: merges the in-order pipe writeback with results from
// a multi-cycle (mul/div) unit onto one register-file write port. md results
// wait in a 2-entry FIFO. The pipe normally wins. A starvation counter forces a
// one-cycle DRAIN that stalls the pipe and writes the FIFO head.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_wd,
  input  logic [63:0] pipe_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_wd,
  input  logic [63:0] md_data,
  output logic        stall_pipe,
  output logic        wb_en,
  output logic [4:0]  wb_wd,
  output logic [63:0] wb_data,
  output logic [1:0]  md_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  wd;
    logic [63:0] data;
  } wb_req_t;

  typedef enum logic {NORMAL, DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  wb_req_t           r_fifo [0:1];
  logic              r_rd_ptr, r_wr_ptr;
  logic [1:0]        r_count;
  logic [SW-1:0]     r_starve, w_starve_nxt;
  logic              r_wb_en;
  wb_req_t           r_wb;

  logic              w_push, w_grant_pipe, w_grant_md, w_wr;
  wb_req_t           w_grant_req, w_md_req;

  // Acceptance depends only on the registered count, so a pop in the same
  // cycle never opens a slot for a push into a full FIFO.
  assign md_ready   = !rst && (r_count != 2'd2);
  assign w_push     = md_valid && md_ready;
  assign w_md_req   = '{wd: md_wd, data: md_data};
  assign stall_pipe = (r_state == DRAIN);
  assign md_count   = r_count;
  assign wb_en      = r_wb_en;
  assign wb_wd      = r_wb.wd;
  assign wb_data    = r_wb.data;

  // Grant selection, starvation counter update and next state. The head is
  // judged by the registered count, so an entry pushed this cycle is not
  // grantable until next cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_pipe = 1'b0;
    w_grant_md   = 1'b0;
    case (r_state)
      NORMAL: begin
        if (pipe_valid && (pipe_wd != 5'd0)) w_grant_pipe = 1'b1;
        else if (r_count != 2'd0)            w_grant_md   = 1'b1;
      end
      DRAIN: begin
        w_grant_md  = (r_count != 2'd0);
        w_state_nxt = NORMAL;
      end
      default: w_state_nxt = NORMAL;
    endcase

    if (w_grant_md || (r_count == 2'd0)) w_starve_nxt = '0;
    else                                 w_starve_nxt = r_starve + SW'(1);

    if ((r_state == NORMAL) && (w_starve_nxt == SW'(STARVE_LIMIT)))
      w_state_nxt = DRAIN;

    w_grant_req = w_grant_pipe ? '{wd: pipe_wd, data: pipe_data} : r_fifo[r_rd_ptr];
    // x0 destinations are granted (md entries still pop) but never written.
    w_wr        = (w_grant_pipe || w_grant_md) && (w_grant_req.wd != 5'd0);
  end

  // FSM state and starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= NORMAL;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // md result FIFO: pointers, occupancy and storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_md_req;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_grant_md) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_grant_md})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_en <= 1'b0;
      r_wb    <= '0;
    end else begin
      r_wb_en <= w_wr;
      if (w_wr) r_wb <= w_grant_req;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a table of per-cycle vectors with hand-derived
// expectations, a queue of expected register-file writes, and a hand-written
// mid-operation reset sequence.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_wd;
  logic [63:0] pipe_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_wd;
  logic [63:0] md_data;
  logic        stall_pipe;
  logic        wb_en;
  logic [4:0]  wb_wd;
  logic [63:0] wb_data;
  logic [1:0]  md_count;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_wd(pipe_wd), .pipe_data(pipe_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_wd(md_wd), .md_data(md_data),
    .stall_pipe(stall_pipe), .wb_en(wb_en), .wb_wd(wb_wd), .wb_data(wb_data),
    .md_count(md_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;  logic [4:0] pwd; logic [63:0] pd;
    logic        mv;  logic [4:0] mwd; logic [63:0] md;
    logic [1:0]  cnt; logic rdy; logic stl;
    logic        wr;  logic [4:0] wd;  logic [63:0] wdata;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [4:0]  wd;
    logic [63:0] data;
  } wr_t;

  vec_t tbl[$];
  wr_t  sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t v(input logic pv, input logic [4:0] pwd, input logic [63:0] pd,
                             input logic mv, input logic [4:0] mwd, input logic [63:0] md,
                             input logic [1:0] cnt, input logic rdy, input logic stl,
                             input logic wr, input logic [4:0] wd, input logic [63:0] wdata);
    vec_t r;
    r.pv = pv; r.pwd = pwd; r.pd = pd; r.mv = mv; r.mwd = mwd; r.md = md;
    r.cnt = cnt; r.rdy = rdy; r.stl = stl; r.wr = wr; r.wd = wd; r.wdata = wdata;
    return r;
  endfunction

  // Compare any write seen on the port against the oldest expected write.
  task automatic monitor();
    wr_t e;
    if (wb_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_wd", {59'd0, wb_wd}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("write_cycle", 64'(cyc), 64'(e.cyc));
        chk("write_wd", {59'd0, wb_wd}, {59'd0, e.wd});
        chk("write_data", wb_data, e.data);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk("missing_write_wd", 64'd0, {59'd0, e.wd});
    end
  endtask

  task automatic drive(input vec_t r);
    pipe_valid = r.pv; pipe_wd = r.pwd; pipe_data = r.pd;
    md_valid   = r.mv; md_wd   = r.mwd; md_data   = r.md;
  endtask

  task automatic step(input vec_t r);
    wr_t e;
    drive(r);
    if (r.wr) begin
      e.cyc = cyc + 1; e.wd = r.wd; e.data = r.wdata;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cyc++;
    chk("md_count", 64'(md_count), 64'(r.cnt));
    chk("md_ready", 64'(md_ready), 64'(r.rdy));
    chk("stall_pipe", 64'(stall_pipe), 64'(r.stl));
    monitor();
  endtask

  vec_t idle;

  initial begin
    idle = v(0,0,0, 0,0,0, 0,1,0, 0,0,0);
    rst = 1'b1;
    drive(idle);

    // Reset values while rst is held high.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_md_count", 64'(md_count), 64'd0);
    chk("rst_md_ready", 64'(md_ready), 64'd0);
    chk("rst_stall", 64'(stall_pipe), 64'd0);
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_wb_wd", 64'(wb_wd), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_md_ready", 64'(md_ready), 64'd1);

    // Pipe-only write.
    tbl.push_back(v(1,5,64'hAA, 0,0,0, 0,1,0, 1,5,64'hAA));
    tbl.push_back(idle);
    // Single md result on an idle pipe: queued, written one cycle later.
    tbl.push_back(v(0,0,0, 1,7,64'h1234, 1,1,0, 0,0,0));
    tbl.push_back(v(0,0,0, 0,0,0,        0,1,0, 1,7,64'h1234));
    tbl.push_back(idle);
    // Busy pipe starves one md result until the one-cycle drain.
    tbl.push_back(v(1,3,64'h10, 1,12,64'hBEEF, 1,1,0, 1,3,64'h10));
    tbl.push_back(v(1,3,64'h11, 0,0,0, 1,1,0, 1,3,64'h11));
    tbl.push_back(v(1,3,64'h12, 0,0,0, 1,1,0, 1,3,64'h12));
    tbl.push_back(v(1,3,64'h13, 0,0,0, 1,1,0, 1,3,64'h13));
    tbl.push_back(v(1,3,64'h14, 0,0,0, 1,1,1, 1,3,64'h14));
    tbl.push_back(v(1,3,64'h15, 0,0,0, 0,1,0, 1,12,64'hBEEF));
    tbl.push_back(v(1,3,64'h15, 0,0,0, 0,1,0, 1,3,64'h15));
    tbl.push_back(idle);
    // Two md results fill the FIFO; a third is held off until a pop.
    tbl.push_back(v(1,3,64'h20, 1,8,64'h801,  1,1,0, 1,3,64'h20));
    tbl.push_back(v(1,3,64'h21, 1,9,64'h901,  2,0,0, 1,3,64'h21));
    tbl.push_back(v(1,3,64'h22, 1,10,64'hA01, 2,0,0, 1,3,64'h22));
    tbl.push_back(v(1,3,64'h23, 1,10,64'hA01, 2,0,0, 1,3,64'h23));
    tbl.push_back(v(1,3,64'h24, 1,10,64'hA01, 2,0,1, 1,3,64'h24));
    tbl.push_back(v(1,3,64'h25, 1,10,64'hA01, 1,1,0, 1,8,64'h801));
    tbl.push_back(v(1,3,64'h25, 1,10,64'hA01, 2,0,0, 1,3,64'h25));
    tbl.push_back(v(0,0,0, 0,0,0, 1,1,0, 1,9,64'h901));
    tbl.push_back(v(0,0,0, 0,0,0, 0,1,0, 1,10,64'hA01));
    tbl.push_back(idle);
    // Pipe to x0 alongside a queued md head: the md result takes the port.
    tbl.push_back(v(0,0,0,        1,9,64'h99, 1,1,0, 0,0,0));
    tbl.push_back(v(1,0,64'hDEAD, 0,0,0,      0,1,0, 1,9,64'h99));
    tbl.push_back(idle);
    // md result to x0 is accepted and popped silently; lone pipe x0 writes nothing.
    tbl.push_back(v(0,0,0,        1,0,64'h55, 1,1,0, 0,0,0));
    tbl.push_back(v(0,0,0,        0,0,0,      0,1,0, 0,0,0));
    tbl.push_back(v(1,0,64'hBAD,  0,0,0,      0,1,0, 0,0,0));
    // Push and pop in the same cycle keep the count and the order.
    tbl.push_back(v(0,0,0, 1,4,64'h44, 1,1,0, 0,0,0));
    tbl.push_back(v(0,0,0, 1,6,64'h66, 1,1,0, 1,4,64'h44));
    tbl.push_back(v(0,0,0, 0,0,0,      0,1,0, 1,6,64'h66));
    tbl.push_back(idle);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Fill the FIFO, then reset asynchronously between clock edges.
    step(v(1,3,64'h30, 1,11,64'h1111, 1,1,0, 1,3,64'h30));
    step(v(1,3,64'h31, 1,13,64'h1313, 2,0,0, 1,3,64'h31));
    drive(idle);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_md_count", 64'(md_count), 64'd0);
    chk("async_rst_md_ready", 64'(md_ready), 64'd0);
    chk("async_rst_wb_en", 64'(wb_en), 64'd0);
    chk("async_rst_stall", 64'(stall_pipe), 64'd0);
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    #1;
    chk("rearm_md_ready", 64'(md_ready), 64'd1);
    // Nothing queued before reset may ever reach the write port.
    for (int i = 0; i < 8; i++) step(idle);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #20000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: cycles a queued mul/div result may wait before the pipe is stalled.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pipe_valid  input  1  in-order pipeline writeback request this cycle.
REQ-005 SHALL have port pipe_wd  input  5  pipeline destination register.
REQ-006 SHALL have port pipe_data  input  64  pipeline writeback data.
REQ-007 SHALL have port md_valid  input  1  multi-cycle (mul/div) unit result valid.
REQ-008 SHALL have port md_ready  output  1  arbiter can accept an md result this cycle.
REQ-009 SHALL have port md_wd  input  5  md destination register.
REQ-010 SHALL have port md_data  input  64  md result data.
REQ-011 SHALL have port stall_pipe  output  1  pipe must hold its request; pipe request ignored this cycle.
REQ-012 SHALL have port wb_en  output  1  register-file write enable.
REQ-013 SHALL have port wb_wd  output  5  register-file write address.
REQ-014 SHALL have port wb_data  output  64  register-file write data.
REQ-015 SHALL have port md_count  output  2  md results currently queued (0..2).

Function
REQ-016 SHALL queue md results in a 2-entry FIFO; push when md_valid && md_ready.
REQ-017 SHALL drive md_ready = (md_count < 2), computed from registered count; no push when full, even if a pop occurs the same cycle.
REQ-018 SHALL grant exactly one writer per cycle to the single register-file write port.
REQ-019 SHALL implement FSM states NORMAL and DRAIN; stall_pipe = (state == DRAIN), registered.
REQ-020 NORMAL: pipe_valid && pipe_wd != 0 -> pipe granted; otherwise FIFO head granted if md_count > 0.
REQ-021 DRAIN: FIFO head granted unconditionally; pipe request ignored.
REQ-022 SHALL hold a starvation counter: reset to 0 on any head grant or when md_count == 0; increment by 1 each cycle md_count > 0 and the head is not granted.
REQ-023 NORMAL -> DRAIN when the counter, after update, equals STARVE_LIMIT; DRAIN -> NORMAL after exactly one cycle; the counter clears on the DRAIN grant.
REQ-024 SHALL register grant results into wb_en/wb_wd/wb_data: one-cycle latency from request to write.
REQ-025 SHALL suppress writes to x0: a grant with wd == 0 gives wb_en = 0, and a pipe request with wd == 0 consumes no port slot.
REQ-026 md entries with md_wd == 0 SHALL be accepted and popped with wb_en = 0.
REQ-027 No grant cycle SHALL give wb_en = 0, with wb_wd/wb_data holding their previous values.
REQ-028 Same-cycle push into an empty FIFO SHALL NOT be granted that cycle; the head becomes grantable next cycle.
REQ-029 Simultaneous push and pop SHALL leave md_count unchanged, with FIFO order preserved.
REQ-030 Write-after-write ordering between pipe and md to the same register is the issue logic's responsibility; the arbiter SHALL NOT reorder within the FIFO.

Reset
REQ-031 While rst is high: state = NORMAL, FIFO empty, md_count = 0, starvation counter = 0, stall_pipe = 0, wb_en = 0, wb_wd = 0, wb_data = 0, md_ready = 0.
REQ-032 Reset asserted mid-operation SHALL discard queued md results; no write issues from pre-reset state.
REQ-033 After rst deasserts, md_ready SHALL be 1 on the first cycle.

Verification
REQ-034 Pipe only: pipe_valid=1, wd=5, data=0xAA for 1 cycle -> next cycle wb_en=1, wb_wd=5, wb_data=0xAA; stall_pipe stays 0.
REQ-035 Idle pipe with md push wd=7, data=0x1234 -> md_count=1 one cycle later; the cycle after that wb_en=1, wb_wd=7, wb_data=0x1234; md_count returns to 0.
REQ-036 Continuous pipe_valid (wd=3) with one md push -> starvation counter reaches 4, stall_pipe=1 for exactly 1 cycle, md result written, then pipe writes resume.
REQ-037 Two md pushes with pipe busy -> md_count=2, md_ready=0, and a third md_valid is not accepted until a pop occurs.
REQ-038 Pipe wd=0 and md head wd=9 in the same cycle -> md written (wb_wd=9), no x0 write.
REQ-039 md_count=2 then rst pulsed -> md_count=0, wb_en=0, and no queued result is ever written.
